hotcache_multi: RTL
===================

HOTCACHE_MULTI -- requirements
Module: hotcache_multi

Interface
REQ-001 Parameter DATA_W, default 16: cached data width.
REQ-002 Parameter NREGS, default 4, power of 2: cacheable index registers; reg field width REG_W = log2(NREGS)+1.
REQ-003 Parameter LINES, default 8, power of 2: lines per index register, halfword stride (2).
REQ-004 Parameter OFF_W, default 16: offset width.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 a_rst  in  1  reset, synchronous, active-high.
REQ-007 rd_valid  in  1  read lookup qualifier (statistics only).
REQ-008 rd_reg  in  REG_W  index register of lookup.
REQ-009 rd_offset  in  OFF_W  relative offset of lookup.
REQ-010 rd_data  out  DATA_W  cached data at {rd_reg, line}.
REQ-011 rd_cached  out  1  lookup hit.
REQ-012 crb_commit  in  1  Common Result Bus commit.
REQ-013 crb_reg  in  REG_W  register written by commit.
REQ-014 fill_valid / fill_ready  in / out  1 / 1  fill handshake.
REQ-015 fill_reg, fill_offset, fill_data  in  REG_W, OFF_W, DATA_W  fill payload.
REQ-016 st_valid  in  1  store snoop; st_reg, st_offset, st_data  in  REG_W, OFF_W, DATA_W.
REQ-017 flush_req  in  1  start full flush; busy  out  1  flush in progress.
REQ-018 hit_count, miss_count  out  16 each  saturating lookup statistics.

Function
REQ-019 Cacheable: reg MSB = 1, offset[0] = 0, offset < 2*LINES; slot = {reg[REG_W-2:0], offset[log2(LINES):1]}; non-cacheable operations ignored (fill still handshakes and completes as no-op).
REQ-020 rd_cached combinational = cacheable & valid[slot] & ~busy & ~(crb_commit & crb_reg == rd_reg); rd_data combinational from data array, zero when not cached.
REQ-021 Fill transfer occurs when fill_valid & fill_ready; fill_ready = ~busy; transfer writes data and sets valid[slot] next edge.
REQ-022 Commit with crb_reg MSB = 1 clears every valid bit of that register next edge; commit beats same-cycle fill to the same register (line ends invalid, data still written).
REQ-023 Store snoop to a valid cacheable slot updates its data, valid kept (write-update); store to invalid slot no effect.
REQ-024 Single data write port: priority flush sweep > fill > store; a store losing the port to a fill on a different slot invalidates its own slot; store and fill on same slot: fill data wins.
REQ-025 Commit on same cycle as a store to that register: line invalid next cycle.
REQ-026 FSM IDLE -> FLUSH on flush_req (ignored in FLUSH); FLUSH clears all valid bits on entry, zeroes one data slot per cycle from slot 0 upward, returns to IDLE after slot NREGS*LINES-1; busy = (state == FLUSH), NREGS*LINES cycles at defaults 32.
REQ-027 During FLUSH: fills stalled, stores and commits ignored, lookups miss, statistics frozen.
REQ-028 On rd_valid in IDLE: rd_cached increments hit_count else miss_count; both saturate at 0xFFFF; both cleared on FLUSH entry.
REQ-029 Zero latency for lookup; one-cycle latency for fill/store/commit visibility.

Reset
REQ-030 a_rst high at edge: state IDLE, all valid bits 0, counters 0; busy 0, fill_ready 1, rd_cached 0 next cycle; data array not reset.
REQ-031 Reset mid-flush aborts sweep; IDLE with all lines invalid.

Structure
REQ-032 Shared package holds FSM state enum, stride constant, counter width 16, cacheability/slot function.
REQ-033 One sub-module natural: hotcache_sweep (flush FSM + slot counter + busy).

Verification
REQ-034 Fill r5 off 0x6 data 0xBEEF; next cycle read r5/0x6 -> rd_cached 1, rd_data 0xBEEF; read r5/0x7 -> miss.
REQ-035 Fill r6 off 0x2 with commit r6 same cycle -> next cycle read r6/0x2 misses; r4 lines unaffected.
REQ-036 Valid r4/0x0 = 0x1111; store r4/0x0 0x2222 -> hit 0x2222; same cycle fill r4/0x2 + store r4/0x0 -> r4/0x0 misses, r4/0x2 hits.
REQ-037 Fill 4 lines, flush_req -> busy exactly 32 cycles, fill_ready 0, all reads miss, counters 0 after; a_rst in cycle 10 -> busy 0 next cycle.
REQ-038 70000 hit lookups -> hit_count 0xFFFF, miss_count unchanged; read r1/0x0 (MSB 0) -> miss counted.

Source files
------------

// File: rtl/hotcache_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hotcache_multi_pkg
// Brief    : Shared types, constants and cacheability helpers for the
//            hot-line cache of index-register relative loads.
// Revision : 1.0 - initial release
// ============================================================================
package hotcache_multi_pkg;

    // Flush sequencer states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } sweep_state_e;

    // Lines are halfword spaced within an index register window
    localparam int c_stride = 2;

    // Width of the saturating hit/miss statistics
    localparam int c_cnt_w = 16;

    // A lookup is cacheable when the register is one of the upper (cached)
    // index registers, the offset is halfword aligned and inside the window.
    function automatic logic is_cacheable(
        input logic [31:0] reg_v,
        input logic [31:0] off,
        input int          reg_w,
        input int          lines
    );
        return reg_v[reg_w-1] & ~off[0] & (off < 32'(c_stride * lines));
    endfunction

    // Flat slot number {reg index without MSB, line}; only meaningful when
    // is_cacheable() holds for the same operands.
    function automatic logic [31:0] slot_of(
        input logic [31:0] reg_v,
        input logic [31:0] off,
        input int          reg_w,
        input int          lines
    );
        logic [31:0] idx;
        idx = reg_v & ((32'd1 << (reg_w - 1)) - 32'd1);
        return (idx * 32'(lines)) + (off / 32'(c_stride));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hotcache_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : hotcache_multi_if
// Brief    : Lookup / commit / fill / store-snoop / flush bundle of the
//            hot-line cache. master = pipeline side, slave = cache side.
// Revision : 1.0 - initial release
// ============================================================================
interface hotcache_multi_if
    import hotcache_multi_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 4,
    parameter int LINES  = 8,
    parameter int OFF_W  = 16
);
    localparam int REG_W = $clog2(NREGS) + 1;

    // lookup
    logic                rd_valid;
    logic [REG_W-1:0]    rd_reg;
    logic [OFF_W-1:0]    rd_offset;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_cached;
    // result bus commit
    logic                crb_commit;
    logic [REG_W-1:0]    crb_reg;
    // fill
    logic                fill_valid;
    logic                fill_ready;
    logic [REG_W-1:0]    fill_reg;
    logic [OFF_W-1:0]    fill_offset;
    logic [DATA_W-1:0]   fill_data;
    // store snoop
    logic                st_valid;
    logic [REG_W-1:0]    st_reg;
    logic [OFF_W-1:0]    st_offset;
    logic [DATA_W-1:0]   st_data;
    // flush and statistics
    logic                flush_req;
    logic                busy;
    logic [c_cnt_w-1:0]  hit_count;
    logic [c_cnt_w-1:0]  miss_count;

    modport master (
        output rd_valid, rd_reg, rd_offset,
        output crb_commit, crb_reg,
        output fill_valid, fill_reg, fill_offset, fill_data,
        output st_valid, st_reg, st_offset, st_data,
        output flush_req,
        input  rd_data, rd_cached, fill_ready, busy, hit_count, miss_count
    );

    modport slave (
        input  rd_valid, rd_reg, rd_offset,
        input  crb_commit, crb_reg,
        input  fill_valid, fill_reg, fill_offset, fill_data,
        input  st_valid, st_reg, st_offset, st_data,
        input  flush_req,
        output rd_data, rd_cached, fill_ready, busy, hit_count, miss_count
    );

endinterface
`default_nettype wire

// File: rtl/hotcache_sweep.sv
`default_nettype none
// ============================================================================
// Module   : hotcache_sweep
// Brief    : Flush sequencer: IDLE/FLUSH state, data-slot sweep counter and
//            busy flag. One slot is zeroed per FLUSH cycle, slot 0 upward.
// Revision : 1.0 - initial release
// ============================================================================
module hotcache_sweep
    import hotcache_multi_pkg::*;
#(
    parameter int SLOT_W = 5
) (
    input  logic              clk,
    input  logic              a_rst,
    input  logic              i_flush_req,
    output logic              o_busy,
    output logic              o_flush_start,
    output logic [SLOT_W-1:0] o_slot
);

    localparam logic [0:0]        c_st_idle  = ST_IDLE;
    localparam logic [0:0]        c_st_flush = ST_FLUSH;
    localparam logic [SLOT_W-1:0] c_last     = '1;

    logic [0:0]        r_state;
    logic [SLOT_W-1:0] r_slot;

    // State and sweep pointer; the sweep ends after the last slot is zeroed
    always_ff @(posedge clk) begin
        if (a_rst) begin
            r_state <= c_st_idle;
            r_slot  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_slot <= '0;
                    if (i_flush_req) begin
                        r_state <= c_st_flush;
                    end
                end
                c_st_flush: begin
                    r_slot <= r_slot + SLOT_W'(1);
                    if (r_slot == c_last) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_slot  <= '0;
                end
            endcase
        end
    end

    assign o_busy        = (r_state == c_st_flush);
    assign o_flush_start = (r_state == c_st_idle) & i_flush_req;
    assign o_slot        = r_slot;

endmodule
`default_nettype wire

// File: rtl/hotcache_multi.sv
`default_nettype none
// ============================================================================
// Module   : hotcache_multi
// Brief    : Hot-line cache for index-register relative loads. Zero-latency
//            lookup, fills and store snoops share one data write port,
//            result-bus commits invalidate a whole register window, and a
//            flush sequencer clears the array one slot per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module hotcache_multi
    import hotcache_multi_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 4,
    parameter int LINES  = 8,
    parameter int OFF_W  = 16
) (
    input  logic            clk,
    input  logic            a_rst,
    hotcache_multi_if.slave bus
);

    localparam int REG_W  = $clog2(NREGS) + 1;
    localparam int LINE_W = $clog2(LINES);
    localparam int NSLOTS = NREGS * LINES;
    localparam int SLOT_W = $clog2(NSLOTS);

    logic [DATA_W-1:0]  r_data [NSLOTS];
    logic [NSLOTS-1:0]  r_valid;
    logic [c_cnt_w-1:0] r_hit_count;
    logic [c_cnt_w-1:0] r_miss_count;

    logic [OFF_W-1:0]   w_rd_off;
    logic [OFF_W-1:0]   w_fill_off;
    logic [OFF_W-1:0]   w_st_off;
    logic               w_rd_ok;
    logic               w_fill_ok;
    logic               w_st_hit;
    logic               w_st_ok;
    logic               w_st_evict;
    logic               w_commit;
    logic               w_rd_killed;
    logic               w_rd_cached;
    logic [SLOT_W-1:0]  w_rd_slot;
    logic [SLOT_W-1:0]  w_fill_slot;
    logic [SLOT_W-1:0]  w_st_slot;
    logic [NSLOTS-1:0]  w_commit_mask;
    logic [NSLOTS-1:0]  w_valid_next;
    logic               w_busy;
    logic               w_flush_start;
    logic [SLOT_W-1:0]  w_sweep_slot;

    hotcache_sweep #(
        .SLOT_W (SLOT_W)
    ) u_sweep (
        .clk           (clk),
        .a_rst         (a_rst),
        .i_flush_req   (bus.flush_req),
        .o_busy        (w_busy),
        .o_flush_start (w_flush_start),
        .o_slot        (w_sweep_slot)
    );

    assign w_rd_off   = bus.rd_offset;
    assign w_fill_off = bus.fill_offset;
    assign w_st_off   = bus.st_offset;

    assign w_rd_slot   = SLOT_W'(slot_of(32'(bus.rd_reg),   32'(w_rd_off),   REG_W, LINES));
    assign w_fill_slot = SLOT_W'(slot_of(32'(bus.fill_reg), 32'(w_fill_off), REG_W, LINES));
    assign w_st_slot   = SLOT_W'(slot_of(32'(bus.st_reg),   32'(w_st_off),   REG_W, LINES));

    assign w_rd_ok = is_cacheable(32'(bus.rd_reg), 32'(w_rd_off), REG_W, LINES);

    // A fill handshakes whenever the cache is not flushing, but only a
    // cacheable one touches the array.
    assign bus.fill_ready = ~w_busy;
    assign w_fill_ok = bus.fill_valid & ~w_busy &
                       is_cacheable(32'(bus.fill_reg), 32'(w_fill_off), REG_W, LINES);

    // Store snoop is write-update: only lines already valid are touched.
    assign w_st_hit = bus.st_valid & ~w_busy &
                      is_cacheable(32'(bus.st_reg), 32'(w_st_off), REG_W, LINES);
    assign w_st_ok    = w_st_hit & r_valid[w_st_slot];
    // A store that loses the write port to a fill elsewhere can no longer
    // keep its line coherent, so the line is dropped instead.
    assign w_st_evict = w_st_ok & w_fill_ok & (w_st_slot != w_fill_slot);

    assign w_commit = bus.crb_commit & ~w_busy & bus.crb_reg[REG_W-1];

    // A commit in the same cycle means the register just changed under us
    assign w_rd_killed = bus.crb_commit & (bus.crb_reg == bus.rd_reg);
    assign w_rd_cached = w_rd_ok & r_valid[w_rd_slot] & ~w_busy & ~w_rd_killed;

    assign bus.rd_cached  = w_rd_cached;
    assign bus.rd_data    = w_rd_cached ? r_data[w_rd_slot] : '0;
    assign bus.busy       = w_busy;
    assign bus.hit_count  = r_hit_count;
    assign bus.miss_count = r_miss_count;

    // Lines belonging to the register named on the commit bus
    always_comb begin
        w_commit_mask = '0;
        for (int l = 0; l < LINES; l++) begin
            w_commit_mask[{bus.crb_reg[REG_W-2:0], LINE_W'(l)}] = 1'b1;
        end
    end

    // Next valid vector: commit is applied last so it beats a fill or store
    always_comb begin
        w_valid_next = r_valid;
        if (w_st_evict) begin
            w_valid_next[w_st_slot] = 1'b0;
        end
        if (w_fill_ok) begin
            w_valid_next[w_fill_slot] = 1'b1;
        end
        if (w_commit) begin
            w_valid_next = w_valid_next & ~w_commit_mask;
        end
    end

    // Valid bits: cleared by reset and on flush entry, otherwise updated
    always_ff @(posedge clk) begin
        if (a_rst || w_flush_start) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_next;
        end
    end

    // Single data write port: sweep, then fill, then store
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_data[w_sweep_slot] <= '0;
        end else if (w_fill_ok) begin
            r_data[w_fill_slot] <= bus.fill_data;
        end else if (w_st_ok) begin
            r_data[w_st_slot] <= bus.st_data;
        end
    end

    // Saturating lookup statistics, frozen while flushing
    always_ff @(posedge clk) begin
        if (a_rst || w_flush_start) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (bus.rd_valid && !w_busy) begin
            if (w_rd_cached) begin
                if (r_hit_count != '1) begin
                    r_hit_count <= r_hit_count + c_cnt_w'(1);
                end
            end else begin
                if (r_miss_count != '1) begin
                    r_miss_count <= r_miss_count + c_cnt_w'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
